// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - frame constants, FSM state type and drop-counter helper
package uart_frame_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] TYPE_MEAS = 8'h01;
  localparam logic [7:0] TYPE_STAT = 8'h02;
  localparam logic [7:0] TYPE_HB   = 8'h03;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    NEXT
  } state_t;

  // Adds up to two drop events to an 8-bit counter, pinning at 255
  function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, base} + {7'd0, inc};
    return (sum > 9'd255) ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/pending_slot.sv
// rtl/pending_slot.sv - one-entry pending buffer with same-cycle refill and drop pulse
module pending_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         stb,
  input  logic [W-1:0] din,
  input  logic         take,
  output logic         full,
  output logic [W-1:0] dout,
  output logic         drop
);

  // A strobe is lost only when the slot is occupied and not being emptied this cycle
  assign drop = stb && full && !take;

  // Store on strobe into an empty (or emptying) slot; set wins over take
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full <= 1'b0;
      dout <= '0;
    end else if (stb && (!full || take)) begin
      full <= 1'b1;
      dout <= din;
    end else if (take) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_frame_scheduler.sv
// rtl/uart_frame_scheduler.sv - arbitrates meas/stat/heartbeat frames onto one uart_tx
module uart_frame_scheduler
  import uart_frame_pkg::*;
#(
  parameter int MEAS_W    = 32,
  parameter int HB_PERIOD = 50_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              meas_stb,
  input  logic [MEAS_W-1:0] meas_data,
  input  logic              stat_stb,
  input  logic [7:0]        stat_data,
  output logic              tx_dv,
  output logic [7:0]        tx_byte,
  input  logic              tx_active,
  input  logic              tx_done,
  output logic              busy,
  output logic [7:0]        drop_cnt
);

  localparam int PAY_BYTES = MEAS_W / 8;
  localparam int IDX_W     = $clog2(PAY_BYTES + 3);

  state_t            state;
  logic [IDX_W-1:0]  byte_idx;
  logic [IDX_W-1:0]  last_idx;
  logic [7:0]        frame_type;
  logic [7:0]        chk_acc;
  logic [7:0]        cur_byte;
  logic [MEAS_W-1:0] pay_sr;

  logic              meas_full;
  logic              meas_drop;
  logic [MEAS_W-1:0] meas_dout;
  logic              stat_full;
  logic              stat_drop;
  logic [7:0]        stat_dout;
  logic              take_meas;
  logic              take_stat;
  logic              take_hb;
  logic              hb_pend;
  logic              hb_tick;

  pending_slot #(.W(MEAS_W)) u_meas_slot (
    .clk     (clk),
    .reset_n (reset_n),
    .stb     (meas_stb),
    .din     (meas_data),
    .take    (take_meas),
    .full    (meas_full),
    .dout    (meas_dout),
    .drop    (meas_drop)
  );

  pending_slot #(.W(8)) u_stat_slot (
    .clk     (clk),
    .reset_n (reset_n),
    .stb     (stat_stb),
    .din     (stat_data),
    .take    (take_stat),
    .full    (stat_full),
    .dout    (stat_dout),
    .drop    (stat_drop)
  );

  assign busy = (state != IDLE);

  // Fixed priority meas > stat > heartbeat, only granted while idle
  always_comb begin
    take_meas = 1'b0;
    take_stat = 1'b0;
    take_hb   = 1'b0;
    if (state == IDLE) begin
      if (meas_full) begin
        take_meas = 1'b1;
      end else if (stat_full) begin
        take_stat = 1'b1;
      end else if (hb_pend) begin
        take_hb = 1'b1;
      end
    end
  end

  // Byte mux: SYNC, TYPE, payload MSB-first from the shift register, then CHK
  always_comb begin
    cur_byte = chk_acc;
    if (byte_idx == '0) begin
      cur_byte = SYNC_BYTE;
    end else if (byte_idx == IDX_W'(1)) begin
      cur_byte = frame_type;
    end else if (byte_idx != last_idx) begin
      cur_byte = pay_sr[MEAS_W-1 -: 8];
    end
  end

  generate
    if (HB_PERIOD > 0) begin : g_hb
      logic [31:0] hb_timer;

      assign hb_tick = (hb_timer == 32'(HB_PERIOD - 1));

      // Free-running heartbeat timer, wraps at HB_PERIOD-1
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          hb_timer <= '0;
        end else if (hb_tick) begin
          hb_timer <= '0;
        end else begin
          hb_timer <= hb_timer + 32'd1;
        end
      end
    end else begin : g_no_hb
      assign hb_tick = 1'b0;
    end
  endgenerate

  // Heartbeat request flag; a new tick while pending simply keeps it set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hb_pend <= 1'b0;
    end else if (hb_tick) begin
      hb_pend <= 1'b1;
    end else if (take_hb) begin
      hb_pend <= 1'b0;
    end
  end

  // Saturating count of strobes lost to full slots
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
    end else begin
      drop_cnt <= sat_add8(drop_cnt, {1'b0, meas_drop} + {1'b0, stat_drop});
    end
  end

  // Frame sequencer: load winner, then SEND/WAIT/NEXT per byte over the DV/Done handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      tx_dv      <= 1'b0;
      tx_byte    <= '0;
      byte_idx   <= '0;
      last_idx   <= '0;
      frame_type <= '0;
      chk_acc    <= '0;
      pay_sr     <= '0;
    end else begin
      tx_dv <= 1'b0;
      case (state)
        IDLE: begin
          byte_idx <= '0;
          chk_acc  <= '0;
          if (take_meas) begin
            frame_type <= TYPE_MEAS;
            pay_sr     <= meas_dout;
            last_idx   <= IDX_W'(PAY_BYTES + 2);
            state      <= SEND;
          end else if (take_stat) begin
            frame_type <= TYPE_STAT;
            pay_sr     <= MEAS_W'(stat_dout) << (MEAS_W - 8);
            last_idx   <= IDX_W'(3);
            state      <= SEND;
          end else if (take_hb) begin
            frame_type <= TYPE_HB;
            pay_sr     <= MEAS_W'(drop_cnt) << (MEAS_W - 8);
            last_idx   <= IDX_W'(3);
            state      <= SEND;
          end
        end
        SEND: begin
          if (!tx_active) begin
            tx_dv   <= 1'b1;
            tx_byte <= cur_byte;
            // TYPE and payload bytes feed the checksum; SYNC and CHK do not
            if (byte_idx != '0 && byte_idx != last_idx) begin
              chk_acc <= chk_acc ^ cur_byte;
            end
            state <= WAIT;
          end
        end
        WAIT: begin
          if (tx_done) begin
            state <= NEXT;
          end
        end
        NEXT: begin
          if (byte_idx == last_idx) begin
            state <= IDLE;
          end else begin
            if (byte_idx >= IDX_W'(2)) begin
              pay_sr <= pay_sr << 8;
            end
            byte_idx <= byte_idx + 1'b1;
            state    <= SEND;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// tb/tb_uart_frame_scheduler.sv - scoreboard bench for uart_frame_scheduler
module tb_uart_frame_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Channel 0: heartbeat disabled; channel 1: heartbeat every 1000 cycles
  logic        reset_n   [2];
  logic        meas_stb  [2];
  logic [31:0] meas_data [2];
  logic        stat_stb  [2];
  logic [7:0]  stat_data [2];
  logic        tx_dv     [2];
  logic [7:0]  tx_byte   [2];
  logic        tx_active [2];
  logic        tx_done   [2];
  logic        busy      [2];
  logic [7:0]  drop_cnt  [2];
  logic        hold      [2];
  int          done_cyc  [2];
  int          sync_cyc  [2];

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  int test_cnt = 0;
  int fail_cnt = 0;

  uart_frame_scheduler #(.MEAS_W(32), .HB_PERIOD(0)) dut0 (
    .clk       (clk),
    .reset_n   (reset_n[0]),
    .meas_stb  (meas_stb[0]),
    .meas_data (meas_data[0]),
    .stat_stb  (stat_stb[0]),
    .stat_data (stat_data[0]),
    .tx_dv     (tx_dv[0]),
    .tx_byte   (tx_byte[0]),
    .tx_active (tx_active[0]),
    .tx_done   (tx_done[0]),
    .busy      (busy[0]),
    .drop_cnt  (drop_cnt[0])
  );

  uart_frame_scheduler #(.MEAS_W(32), .HB_PERIOD(1000)) dut1 (
    .clk       (clk),
    .reset_n   (reset_n[1]),
    .meas_stb  (meas_stb[1]),
    .meas_data (meas_data[1]),
    .stat_stb  (stat_stb[1]),
    .stat_data (stat_data[1]),
    .tx_dv     (tx_dv[1]),
    .tx_byte   (tx_byte[1]),
    .tx_active (tx_active[1]),
    .tx_done   (tx_done[1]),
    .busy      (busy[1]),
    .drop_cnt  (drop_cnt[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    test_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int ch);
    return (ch == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic push_b(input int ch, input logic [7:0] b);
    if (ch == 0) exp_q0.push_back(b);
    else exp_q1.push_back(b);
  endtask

  // Reference framing: A5, TYPE, payload MSB-first, XOR of TYPE and payload
  task automatic push_frame(input int ch, input logic [7:0] typ, input logic [31:0] pay, input int nb);
    logic [7:0] chk;
    logic [7:0] b;
    chk = typ;
    push_b(ch, 8'hA5);
    push_b(ch, typ);
    for (int i = nb - 1; i >= 0; i--) begin
      b = pay[i*8 +: 8];
      chk = chk ^ b;
      push_b(ch, b);
    end
    push_b(ch, chk);
  endtask

  // uart_tx stand-in: busy 20 cycles after tx_dv (longer while held), then one done pulse
  task automatic uart_model(input int ch);
    forever begin
      @(negedge clk);
      if (tx_dv[ch]) begin
        tx_active[ch] = 1'b1;
        repeat (20) @(posedge clk);
        while (hold[ch]) @(posedge clk);
        #1;
        tx_active[ch] = 1'b0;
        tx_done[ch]   = 1'b1;
        done_cyc[ch]  = cyc;
        @(posedge clk);
        #1;
        tx_done[ch] = 1'b0;
      end
    end
  endtask

  task automatic monitor(input int ch);
    logic [7:0] want;
    forever begin
      @(negedge clk);
      if (tx_dv[ch] && reset_n[ch]) begin
        if (qsize(ch) == 0) begin
          check($sformatf("unexpected_byte_ch%0d", ch), 32'(tx_byte[ch]), 32'hFFFF_FFFF);
        end else begin
          want = (ch == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          check($sformatf("byte_ch%0d", ch), 32'(tx_byte[ch]), 32'(want));
        end
        if (tx_byte[ch] == 8'hA5) sync_cyc[ch] = cyc;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int ch, input bit do_meas, input logic [31:0] m,
                        input bit do_stat, input logic [7:0] s);
    meas_stb[ch]  = do_meas;
    meas_data[ch] = m;
    stat_stb[ch]  = do_stat;
    stat_data[ch] = s;
    tick(1);
    meas_stb[ch] = 1'b0;
    stat_stb[ch] = 1'b0;
  endtask

  task automatic wait_idle(input int ch, input string name);
    int n;
    n = 0;
    while ((qsize(ch) != 0 || busy[ch]) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, 32'(n >= 5000), 32'd0);
    tick(1);
  endtask

  initial begin : watchdog
    #500_000;
    fail_cnt++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

  initial begin : main
    int s;
    int lat;
    int n;
    int idle;
    int k;
    int exp_drop;
    int t1;
    int t2;
    logic [31:0] m;
    logic [7:0]  sd;

    for (int c = 0; c < 2; c++) begin
      reset_n[c]   = 1'b0;
      meas_stb[c]  = 1'b0;
      meas_data[c] = '0;
      stat_stb[c]  = 1'b0;
      stat_data[c] = '0;
      tx_active[c] = 1'b0;
      tx_done[c]   = 1'b0;
      hold[c]      = 1'b0;
      done_cyc[c]  = 0;
      sync_cyc[c]  = 0;
    end
    fork
      uart_model(0);
      uart_model(1);
      monitor(0);
      monitor(1);
    join_none

    tick(3);
    check("rst_tx_dv", 32'(tx_dv[0]), 32'd0);
    check("rst_tx_byte", 32'(tx_byte[0]), 32'd0);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt[0]), 32'd0);
    reset_n[0] = 1'b1;
    tick(2);

    // T1: single meas frame, SYNC latency and busy fall timing
    push_frame(0, 8'h01, 32'h12345678, 4);
    strobe(0, 1'b1, 32'h12345678, 1'b0, 8'h00);
    s = cyc;
    lat = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (tx_dv[0]) begin
        lat = cyc - s;
        break;
      end
    end
    check("t1_sync_latency", 32'(lat), 32'd2);
    n = 0;
    while (qsize(0) != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (busy[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t1_busy_fall", 32'(cyc - done_cyc[0]), 32'd2);
    tick(1);

    // T2: stat frame
    push_frame(0, 8'h02, 32'h5A, 1);
    strobe(0, 1'b0, 32'h0, 1'b1, 8'h5A);
    wait_idle(0, "t2");

    // T3: simultaneous meas and stat, one idle cycle between frames
    push_frame(0, 8'h01, 32'hDEADBEEF, 4);
    push_frame(0, 8'h02, 32'h00, 1);
    strobe(0, 1'b1, 32'hDEADBEEF, 1'b1, 8'h00);
    n = 0;
    while (qsize(0) > 4 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    idle = 0;
    n = 0;
    while (!tx_dv[0] && n < 300) begin
      @(negedge clk);
      if (!busy[0]) idle++;
      n++;
    end
    check("t3_idle_gap", 32'(idle), 32'd1);
    wait_idle(0, "t3");

    // T4: drops during a stalled frame, double drops and saturation
    m = $urandom;
    push_frame(0, 8'h01, m, 4);
    strobe(0, 1'b1, m, 1'b0, 8'h00);
    tick(3);
    hold[0] = 1'b1;
    m = $urandom;
    push_frame(0, 8'h01, m, 4);
    strobe(0, 1'b1, m, 1'b0, 8'h00);
    strobe(0, 1'b1, $urandom, 1'b0, 8'h00);
    check("t4_drop_one", 32'(drop_cnt[0]), 32'd1);
    sd = 8'($urandom);
    push_frame(0, 8'h02, {24'd0, sd}, 1);
    strobe(0, 1'b0, 32'h0, 1'b1, sd);
    exp_drop = 1;
    for (int i = 0; i < 150; i++) begin
      strobe(0, 1'b1, $urandom, 1'b1, 8'($urandom));
      exp_drop = (exp_drop + 2 > 255) ? 255 : exp_drop + 2;
      if (i == 49) check("t4_drop_double", 32'(drop_cnt[0]), 32'(exp_drop));
    end
    check("t4_drop_sat", 32'(drop_cnt[0]), 32'(exp_drop));
    hold[0] = 1'b0;
    wait_idle(0, "t4");
    check("t4_drop_hold", 32'(drop_cnt[0]), 32'd255);

    // T5: asynchronous reset during the third byte
    push_frame(0, 8'h01, 32'h12345678, 4);
    strobe(0, 1'b1, 32'h12345678, 1'b0, 8'h00);
    n = 0;
    while (qsize(0) > 4 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    #2;
    reset_n[0] = 1'b0;
    #1;
    check("t5_tx_dv", 32'(tx_dv[0]), 32'd0);
    check("t5_tx_byte", 32'(tx_byte[0]), 32'd0);
    check("t5_busy", 32'(busy[0]), 32'd0);
    check("t5_drop_cnt", 32'(drop_cnt[0]), 32'd0);
    exp_q0.delete();
    tick(30);
    reset_n[0] = 1'b1;
    tick(2);
    m = 32'hC0FFEE42;
    push_frame(0, 8'h01, m, 4);
    strobe(0, 1'b1, m, 1'b0, 8'h00);
    wait_idle(0, "t5");

    // Randomized single and simultaneous requests
    for (int i = 0; i < 10; i++) begin
      k  = $urandom_range(0, 2);
      m  = $urandom;
      sd = 8'($urandom);
      if (k != 1) push_frame(0, 8'h01, m, 4);
      if (k != 0) push_frame(0, 8'h02, {24'd0, sd}, 1);
      strobe(0, k != 1, m, k != 0, sd);
      wait_idle(0, "rand");
    end
    check("rand_no_drop", 32'(drop_cnt[0]), 32'd0);

    // T6: heartbeat channel
    reset_n[1] = 1'b1;
    tick(2);
    push_frame(1, 8'h01, 32'h11223344, 4);
    strobe(1, 1'b1, 32'h11223344, 1'b0, 8'h00);
    tick(3);
    push_frame(1, 8'h01, 32'h55667788, 4);
    strobe(1, 1'b1, 32'h55667788, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) strobe(1, 1'b1, $urandom, 1'b0, 8'h00);
    check("t6_drop", 32'(drop_cnt[1]), 32'd3);
    wait_idle(1, "t6_meas");
    push_frame(1, 8'h03, 32'h03, 1);
    wait_idle(1, "t6_hb1");
    t1 = sync_cyc[1];
    push_frame(1, 8'h03, 32'h03, 1);
    wait_idle(1, "t6_hb2");
    t2 = sync_cyc[1];
    check("t6_hb_period", 32'(t2 - t1), 32'd1000);
    n = 0;
    while (cyc < t2 + 940 && n < 2000) begin
      tick(1);
      n++;
    end
    push_frame(1, 8'h01, 32'h0BADF00D, 4);
    push_frame(1, 8'h03, 32'h03, 1);
    strobe(1, 1'b1, 32'h0BADF00D, 1'b0, 8'h00);
    wait_idle(1, "t6_cont");
    check("t6_hb_after_meas", 32'(sync_cyc[1] > t2 + 1000), 32'd1);

    check("q0_empty", 32'(qsize(0)), 32'd0);
    check("q1_empty", 32'(qsize(1)), 32'd0);
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
